// File: rtl/pcie_to_pc_fifo_pkg.sv
// Shared definitions for the card-to-host streaming FIFO: PIO command codes
// and the send-side state encoding.
package pcie_to_pc_fifo_pkg;

  localparam logic [2:0] CMD_COUNT = 3'd1;
  localparam logic [2:0] CMD_ADDR  = 3'd2;
  localparam logic [2:0] CMD_IRQ   = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } send_state_e;

endpackage

// File: rtl/block_ram.sv
// Simple dual-port RAM, one write and one registered read port on one clock;
// read data appears the cycle after r_addr is presented.
module block_ram #(
  parameter int NBITS = 64,
  parameter int ABITS = 5
) (
  input  logic             clock,
  input  logic             w_en,
  input  logic [ABITS-1:0] w_addr,
  input  logic [NBITS-1:0] w_data,
  input  logic [ABITS-1:0] r_addr,
  output logic [NBITS-1:0] r_data
);

  logic [NBITS-1:0] mem [1 << ABITS];

  always_ff @(posedge clock) begin
    if (w_en) mem[w_addr] <= w_data;
    r_data <= mem[r_addr];
  end

endmodule

// File: rtl/fwft_fifo.sv
// Dual-clock first-word-fall-through FIFO with gray-coded pointers; o_data is
// valid combinationally with o_valid, writes while i_ready is low are dropped.
module fwft_fifo #(
  parameter int NBITS = 64,
  parameter int ABITS = 4
) (
  input  logic             reset,
  input  logic             i_clock,
  input  logic             i_valid,
  input  logic [NBITS-1:0] i_data,
  output logic             i_ready,
  input  logic             o_clock,
  output logic             o_valid,
  output logic [NBITS-1:0] o_data,
  input  logic             o_ready
);

  localparam int PW    = ABITS + 1;
  localparam int DEPTH = 1 << ABITS;

  logic [NBITS-1:0] mem [DEPTH];

  logic          rst_meta_q, wr_rst_q;
  logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d;
  logic [PW-1:0] rbin_q, rbin_d, rgray_q, rgray_d;
  logic [PW-1:0] rg1_q, rg2_q, wg1_q, wg2_q;
  logic          push, pop, full;

  // Reset is owned by the read clock; the write side sees a synchronised copy.
  always_ff @(posedge i_clock) begin
    rst_meta_q <= reset;
    wr_rst_q   <= rst_meta_q;
  end

  assign full    = (wgray_q == {~rg2_q[PW-1:PW-2], rg2_q[PW-3:0]});
  assign i_ready = !wr_rst_q && !full;
  assign push    = i_valid && i_ready;

  always_comb begin
    wbin_d  = wbin_q + PW'(push);
    wgray_d = wbin_d ^ (wbin_d >> 1);
  end

  always_ff @(posedge i_clock) begin
    if (wr_rst_q) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rg1_q   <= '0;
      rg2_q   <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rg1_q   <= rgray_q;
      rg2_q   <= rg1_q;
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) mem[wbin_q[ABITS-1:0]] <= i_data;
  end

  assign o_valid = (rgray_q != wg2_q);
  assign o_data  = mem[rbin_q[ABITS-1:0]];
  assign pop     = o_valid && o_ready;

  always_comb begin
    rbin_d  = rbin_q + PW'(pop);
    rgray_d = rbin_d ^ (rbin_d >> 1);
  end

  always_ff @(posedge o_clock) begin
    if (reset) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      wg1_q   <= '0;
      wg2_q   <= '0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      wg1_q   <= wgray_q;
      wg2_q   <= wg1_q;
    end
  end

endmodule

// File: rtl/tpc_stage_buffer.sv
// Ping-pong staging of two 2^BLOCK_LOG2-word blocks; accepts a word per cycle
// unless the block being filled is still full, read port has 1-cycle latency.
module tpc_stage_buffer #(
  parameter int BLOCK_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_vld,
  input  logic [63:0]           in_dat,
  output logic                  in_rdy,
  input  logic                  rel_vld,
  input  logic                  rel_blk,
  output logic [1:0]            block_full,
  input  logic [BLOCK_LOG2:0]   rd_addr,
  output logic [63:0]           rd_dat
);

  logic                  fill_blk_q, fill_blk_d;
  logic [BLOCK_LOG2-1:0] fill_ptr_q, fill_ptr_d;
  logic [1:0]            block_full_q, block_full_d;
  logic                  push;

  assign in_rdy     = !block_full_q[fill_blk_q];
  assign push       = in_vld && in_rdy;
  assign block_full = block_full_q;

  // The fill side never enters a full block, so a release always targets the
  // other index and both updates can land in the same cycle.
  always_comb begin
    fill_blk_d   = fill_blk_q;
    fill_ptr_d   = fill_ptr_q;
    block_full_d = block_full_q;
    if (push) begin
      fill_ptr_d = fill_ptr_q + BLOCK_LOG2'(1);
      if (fill_ptr_q == '1) begin
        block_full_d[fill_blk_q] = 1'b1;
        fill_blk_d               = ~fill_blk_q;
      end
    end
    if (rel_vld) block_full_d[rel_blk] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fill_blk_q   <= 1'b0;
      fill_ptr_q   <= '0;
      block_full_q <= '0;
    end else begin
      fill_blk_q   <= fill_blk_d;
      fill_ptr_q   <= fill_ptr_d;
      block_full_q <= block_full_d;
    end
  end

  block_ram #(.NBITS(64), .ABITS(BLOCK_LOG2 + 1)) u_ram (
    .clock  (clock),
    .w_en   (push),
    .w_addr ({fill_blk_q, fill_ptr_q}),
    .w_data (in_dat),
    .r_addr (rd_addr),
    .r_data (rd_dat)
  );

endmodule

// File: rtl/pcie_to_pc_fifo.sv
// Card-to-host FIFO: stages user words into blocks and issues one write burst
// per block to PIO-described host buffers; bursts start 2 cycles after block full.
module pcie_to_pc_fifo
  import pcie_to_pc_fifo_pkg::*;
#(
  parameter int BLOCK_LOG2 = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] status,
  output logic        interrupt,
  input  logic        pio_wvalid,
  input  logic [63:0] pio_wdata,
  output logic        wr_valid,
  output logic        wr_start,
  output logic [63:0] wr_addr,
  output logic [63:0] wr_data,
  input  logic        wr_ready,
  input  logic        fifo_clock,
  input  logic        fifo_write,
  input  logic [63:0] fifo_write_data,
  output logic        fifo_ready
);

  localparam int AW = 61 - BLOCK_LOG2;

  logic                  cdc_vld, stage_rdy;
  logic [63:0]           cdc_dat;
  logic [1:0]            block_full;
  logic [BLOCK_LOG2:0]   rd_addr;

  send_state_e           state_q, state_d;
  logic                  send_blk_q, send_blk_d;
  logic [BLOCK_LOG2-1:0] beat_q, beat_d;
  logic                  wr_valid_q, wr_valid_d, wr_start_q, wr_start_d;
  logic [AW-1:0]         addr_q, addr_d, addr_pend_q, addr_pend_d;
  logic [15:0]           count_q, count_d, count_pend_q, count_pend_d;
  logic                  desc_pending_q, desc_pending_d;
  logic                  desc_overrun_q, desc_overrun_d;
  logic                  busy_q, busy_d;
  logic [15:0]           blocks_sent_q, blocks_sent_d, matchval_q, matchval_d;
  logic                  irq_en_q, irq_en_d, interrupt_q, interrupt_d;
  logic                  irq_hit;

  fwft_fifo #(.NBITS(64), .ABITS(4)) u_cdc (
    .reset   (reset),
    .i_clock (fifo_clock),
    .i_valid (fifo_write),
    .i_data  (fifo_write_data),
    .i_ready (fifo_ready),
    .o_clock (clock),
    .o_valid (cdc_vld),
    .o_data  (cdc_dat),
    .o_ready (stage_rdy)
  );

  tpc_stage_buffer #(.BLOCK_LOG2(BLOCK_LOG2)) u_stage (
    .clock      (clock),
    .reset      (reset),
    .in_vld     (cdc_vld),
    .in_dat     (cdc_dat),
    .in_rdy     (stage_rdy),
    .rel_vld    (state_q == ST_DONE),
    .rel_blk    (send_blk_q),
    .block_full (block_full),
    .rd_addr    (rd_addr),
    .rd_dat     (wr_data)
  );

  assign irq_hit = irq_en_q && (blocks_sent_q == matchval_q);
  // The RAM is always addressed with the beat that must be on wr_data next
  // cycle, which keeps the data stable through stalls.
  assign rd_addr = {send_blk_q, beat_d};

  always_comb begin
    state_d        = state_q;
    send_blk_d     = send_blk_q;
    beat_d         = beat_q;
    wr_valid_d     = wr_valid_q;
    wr_start_d     = wr_start_q;
    addr_d         = addr_q;
    count_d        = count_q;
    addr_pend_d    = addr_pend_q;
    count_pend_d   = count_pend_q;
    desc_pending_d = desc_pending_q;
    desc_overrun_d = desc_overrun_q;
    busy_d         = busy_q;
    blocks_sent_d  = blocks_sent_q;
    matchval_d     = matchval_q;
    irq_en_d       = irq_en_q;
    interrupt_d    = irq_hit;

    case (state_q)
      ST_IDLE: begin
        if (desc_pending_q) begin
          desc_pending_d = 1'b0;
          if (count_pend_q != '0) begin
            addr_d  = addr_pend_q;
            count_d = count_pend_q;
            busy_d  = 1'b1;
            state_d = ST_ARM;
          end
        end
      end
      ST_ARM: begin
        if (block_full[send_blk_q]) begin
          beat_d  = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!wr_valid_q) begin
          wr_valid_d = 1'b1;
          wr_start_d = 1'b1;
        end else if (wr_ready) begin
          wr_start_d = 1'b0;
          if (beat_q == '1) begin
            wr_valid_d = 1'b0;
            state_d    = ST_DONE;
          end else begin
            beat_d = beat_q + BLOCK_LOG2'(1);
          end
        end
      end
      ST_DONE: begin
        send_blk_d    = ~send_blk_q;
        addr_d        = addr_q + AW'(1);
        count_d       = count_q - 16'd1;
        blocks_sent_d = blocks_sent_q + 16'd1;
        if (count_q == 16'd1) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ARM;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (irq_hit) irq_en_d = 1'b0;

    if (pio_wvalid) begin
      case (pio_wdata[2:0])
        CMD_ADDR: addr_pend_d = pio_wdata[63:3+BLOCK_LOG2];
        CMD_COUNT: begin
          if (desc_pending_q) begin
            desc_overrun_d = 1'b1;
          end else begin
            count_pend_d   = pio_wdata[18+BLOCK_LOG2:3+BLOCK_LOG2];
            desc_pending_d = 1'b1;
          end
        end
        CMD_IRQ: begin
          matchval_d = pio_wdata[31:16];
          irq_en_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      send_blk_q     <= 1'b0;
      beat_q         <= '0;
      wr_valid_q     <= 1'b0;
      wr_start_q     <= 1'b0;
      addr_q         <= '0;
      count_q        <= '0;
      addr_pend_q    <= '0;
      count_pend_q   <= '0;
      desc_pending_q <= 1'b0;
      desc_overrun_q <= 1'b0;
      busy_q         <= 1'b0;
      blocks_sent_q  <= '0;
      matchval_q     <= '0;
      irq_en_q       <= 1'b0;
      interrupt_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      send_blk_q     <= send_blk_d;
      beat_q         <= beat_d;
      wr_valid_q     <= wr_valid_d;
      wr_start_q     <= wr_start_d;
      addr_q         <= addr_d;
      count_q        <= count_d;
      addr_pend_q    <= addr_pend_d;
      count_pend_q   <= count_pend_d;
      desc_pending_q <= desc_pending_d;
      desc_overrun_q <= desc_overrun_d;
      busy_q         <= busy_d;
      blocks_sent_q  <= blocks_sent_d;
      matchval_q     <= matchval_d;
      irq_en_q       <= irq_en_d;
      interrupt_q    <= interrupt_d;
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_start  = wr_start_q;
  assign wr_addr   = {addr_q, {(3 + BLOCK_LOG2){1'b0}}};
  assign interrupt = interrupt_q;
  assign status    = {blocks_sent_q, 13'd0, desc_overrun_q, busy_q, desc_pending_q};

endmodule
